// File: rtl/qos_retry_credit_engine.sv
// QoS admission / retry / credit engine in front of a shared command pool.
// Admits requests under per-class quotas, queues retryable overflow per
// class, issues credit grants as capacity frees and reclaims stale credits.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_*                         request handshake (vld/rdy, retry_ok,
//                                 granted, cls, src)
//   rsp_vld/rsp_retry/rsp_src     one-cycle response pulse
//   gnt_vld/gnt_rdy/gnt_src/cls   credit grant handshake
//   rel_vld/rel_cls               downstream release of one pool entry
//   pool_used, rty_used           occupancy (used+reserved), retry fill
//   err_underflow                 sticky release-underflow flag
// Optional: define RTY_AGE_PROMOTE_EN to let long-waiting FIFO heads be
// granted ahead of higher classes.
module qos_retry_credit_engine #(
    parameter int NUM_CLASS   = 4,
    parameter int SRC_W       = 4,
    parameter int POOL_DEPTH  = 32,
    parameter int RTY_DEPTH   = 16,
    parameter int RESERVE_NUM = 2,
    parameter int TIMEOUT_CYC = 64,
    localparam int CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
    localparam int PU_W  = $clog2(POOL_DEPTH + 1),
    localparam int RU_W  = $clog2(RTY_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             req_retry_ok,
    input  logic             req_granted,
    input  logic [CLS_W-1:0] req_cls,
    input  logic [SRC_W-1:0] req_src,
    output logic             rsp_vld,
    output logic             rsp_retry,
    output logic [SRC_W-1:0] rsp_src,
    output logic             gnt_vld,
    input  logic             gnt_rdy,
    output logic [SRC_W-1:0] gnt_src,
    output logic [CLS_W-1:0] gnt_cls,
    input  logic             rel_vld,
    input  logic [CLS_W-1:0] rel_cls,
    output logic [PU_W-1:0]  pool_used,
    output logic [RU_W-1:0]  rty_used,
    output logic             err_underflow
);

    localparam int PTR_W = (RTY_DEPTH > 1) ? $clog2(RTY_DEPTH) : 1;
    localparam int TM_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PU_W:0]    LIM_NR   = (PU_W+1)'(POOL_DEPTH);
    localparam logic [PU_W:0]    LIM_R    = (PU_W+1)'(POOL_DEPTH - RESERVE_NUM);
    localparam logic [RU_W-1:0]  RTY_MAX  = RU_W'(RTY_DEPTH);
    localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RTY_DEPTH - 1);

    function automatic logic [PU_W:0] quota(input int c);
        int q;
        q = POOL_DEPTH >> (NUM_CLASS - 1 - c);
        return (q < 1) ? (PU_W+1)'(1) : (PU_W+1)'(q);
    endfunction

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [PU_W-1:0]  used_q [NUM_CLASS];
    logic [PU_W-1:0]  used_d [NUM_CLASS];
    logic [PU_W-1:0]  resv_q [NUM_CLASS];
    logic [PU_W-1:0]  resv_d [NUM_CLASS];
    logic [RU_W-1:0]  cnt_q  [NUM_CLASS];
    logic [RU_W-1:0]  cnt_d  [NUM_CLASS];
    logic [PTR_W-1:0] wp_q   [NUM_CLASS];
    logic [PTR_W-1:0] wp_d   [NUM_CLASS];
    logic [PTR_W-1:0] rp_q   [NUM_CLASS];
    logic [PTR_W-1:0] rp_d   [NUM_CLASS];
    logic [TM_W-1:0]  tmr_q  [NUM_CLASS];
    logic [TM_W-1:0]  tmr_d  [NUM_CLASS];
    logic [SRC_W-1:0] mem_q  [NUM_CLASS][RTY_DEPTH];

    logic             rsp_vld_q, rsp_retry_q, gnt_vld_q, err_q;
    logic [SRC_W-1:0] rsp_src_q, gnt_src_q;
    logic [CLS_W-1:0] gnt_cls_q;

    logic [PU_W:0]    t_sum, occ_r, t_g;
    logic [RU_W-1:0]  r_sum;
    logic             cls_room, room_nr, room_r, has_resv;
    logic             adm_ok, q_ok, admit, push, consume, new_adm;
    logic             gnt_free, gnt_go, under;
    logic [CLS_W-1:0] sel;
    logic [NUM_CLASS-1:0] g_room, pop, expire, promo;
    logic [NUM_CLASS-1:0] adm_hit, cons_hit, rel_hit, push_hit;

`ifdef RTY_AGE_PROMOTE_EN
    localparam int AG_W = $clog2(2 * TIMEOUT_CYC + 1);
    localparam logic [AG_W-1:0] AG_MAX = AG_W'(2 * TIMEOUT_CYC);
    logic [AG_W-1:0] age_q [NUM_CLASS];
    logic [AG_W-1:0] age_d [NUM_CLASS];

    for (genvar g = 0; g < NUM_CLASS; g++) begin : g_promo
        assign promo[g] = (age_q[g] >= AG_MAX);
    end

    // Head age restarts whenever the head changes or the FIFO is empty.
    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            age_d[c] = age_q[c];
            if (cnt_q[c] == '0 || pop[c]) age_d[c] = '0;
            else if (age_q[c] < AG_MAX)   age_d[c] = age_q[c] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '{default: '0};
        else     age_q <= age_d;
    end
`else
    assign promo = '0;
`endif

    always_comb begin
        t_sum = '0;
        r_sum = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            t_sum = t_sum + (PU_W+1)'(used_q[c]) + (PU_W+1)'(resv_q[c]);
            r_sum = r_sum + cnt_q[c];
        end
        occ_r    = (PU_W+1)'(used_q[req_cls]) + (PU_W+1)'(resv_q[req_cls]);
        cls_room = occ_r < quota(int'(req_cls));
        room_nr  = cls_room && (t_sum < LIM_NR);
        room_r   = cls_room && (t_sum < LIM_R);
        has_resv = req_granted && (resv_q[req_cls] != '0);
        adm_ok   = 1'b0;
        q_ok     = 1'b0;
        if (has_resv) begin
            adm_ok = 1'b1;
        end else if (!req_retry_ok) begin
            adm_ok = room_nr;
        end else begin
            // Never bypass sources already waiting in this class.
            adm_ok = room_r && (cnt_q[req_cls] == '0);
            q_ok   = !adm_ok && (r_sum < RTY_MAX);
        end
        admit   = req_vld && adm_ok;
        push    = req_vld && q_ok;
        consume = admit && has_resv;
        new_adm = admit && !has_resv;
        under   = rel_vld && (used_q[rel_cls] == '0);

        // Same-cycle new admission takes the last slot before a grant.
        gnt_free = !gnt_vld_q || gnt_rdy;
        t_g      = t_sum + (PU_W+1)'(new_adm);
        gnt_go   = 1'b0;
        sel      = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            g_room[c] = (cnt_q[c] != '0) && (t_g < LIM_R) &&
                        ((PU_W+1)'(used_q[c]) + (PU_W+1)'(resv_q[c]) +
                         (PU_W+1)'(new_adm && req_cls == CLS_W'(c))
                         < quota(c));
            if (g_room[c]) begin
                sel    = CLS_W'(c);
                gnt_go = 1'b1;
            end
        end
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (g_room[c] && promo[c]) sel = CLS_W'(c);
        end
        pop = '0;
        if (gnt_go && gnt_free) pop[sel] = 1'b1;

        for (int c = 0; c < NUM_CLASS; c++) begin
            adm_hit[c]  = admit && (req_cls == CLS_W'(c));
            cons_hit[c] = consume && (req_cls == CLS_W'(c));
            push_hit[c] = push && (req_cls == CLS_W'(c));
            rel_hit[c]  = rel_vld && (rel_cls == CLS_W'(c)) &&
                          (used_q[c] != '0);
            // A consume already clears the timer, so it suppresses expiry.
            expire[c]   = (resv_q[c] != '0) && (tmr_q[c] == TM_LAST) &&
                          !cons_hit[c];
            used_d[c] = used_q[c] + PU_W'(adm_hit[c]) - PU_W'(rel_hit[c]);
            resv_d[c] = resv_q[c] + PU_W'(pop[c]) - PU_W'(cons_hit[c])
                        - PU_W'(expire[c]);
            if (resv_q[c] == '0 || cons_hit[c] || expire[c])
                tmr_d[c] = '0;
            else
                tmr_d[c] = tmr_q[c] + 1'b1;
            cnt_d[c] = cnt_q[c] + RU_W'(push_hit[c]) - RU_W'(pop[c]);
            wp_d[c]  = push_hit[c] ? nxt(wp_q[c]) : wp_q[c];
            rp_d[c]  = pop[c] ? nxt(rp_q[c]) : rp_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[req_cls][wp_q[req_cls]] <= req_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q      <= '{default: '0};
            resv_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            wp_q        <= '{default: '0};
            rp_q        <= '{default: '0};
            tmr_q       <= '{default: '0};
            rsp_vld_q   <= 1'b0;
            rsp_retry_q <= 1'b0;
            rsp_src_q   <= '0;
            gnt_vld_q   <= 1'b0;
            gnt_src_q   <= '0;
            gnt_cls_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            used_q      <= used_d;
            resv_q      <= resv_d;
            cnt_q       <= cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            tmr_q       <= tmr_d;
            rsp_vld_q   <= admit || push;
            rsp_retry_q <= push;
            if (admit || push) rsp_src_q <= req_src;
            err_q       <= err_q || under;
            if (gnt_free) begin
                gnt_vld_q <= gnt_go;
                if (gnt_go) begin
                    gnt_src_q <= mem_q[sel][rp_q[sel]];
                    gnt_cls_q <= sel;
                end
            end
        end
    end

    assign req_rdy       = adm_ok || q_ok;
    assign rsp_vld       = rsp_vld_q;
    assign rsp_retry     = rsp_retry_q;
    assign rsp_src       = rsp_src_q;
    assign gnt_vld       = gnt_vld_q;
    assign gnt_src       = gnt_src_q;
    assign gnt_cls       = gnt_cls_q;
    assign pool_used     = t_sum[PU_W-1:0];
    assign rty_used      = r_sum;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_qos_retry_credit_engine.sv
// Directed testbench for qos_retry_credit_engine.
// Walks admission, retry, grant priority/hold, timeout and underflow.
module tb_qos_retry_credit_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_vld, req_rdy, req_retry_ok, req_granted;
    logic [1:0] req_cls;
    logic [3:0] req_src;
    logic       rsp_vld, rsp_retry;
    logic [3:0] rsp_src;
    logic       gnt_vld, gnt_rdy;
    logic [3:0] gnt_src;
    logic [1:0] gnt_cls;
    logic       rel_vld;
    logic [1:0] rel_cls;
    logic [5:0] pool_used;
    logic [4:0] rty_used;
    logic       err_underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0;
    int n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qos_retry_credit_engine dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_retry_ok (req_retry_ok),
        .req_granted  (req_granted),
        .req_cls      (req_cls),
        .req_src      (req_src),
        .rsp_vld      (rsp_vld),
        .rsp_retry    (rsp_retry),
        .rsp_src      (rsp_src),
        .gnt_vld      (gnt_vld),
        .gnt_rdy      (gnt_rdy),
        .gnt_src      (gnt_src),
        .gnt_cls      (gnt_cls),
        .rel_vld      (rel_vld),
        .rel_cls      (rel_cls),
        .pool_used    (pool_used),
        .rty_used     (rty_used),
        .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rok, input logic g,
                         input logic [1:0] cls, input logic [3:0] src);
        req_vld      = v;
        req_retry_ok = rok;
        req_granted  = g;
        req_cls      = cls;
        req_src      = src;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        gnt_rdy = 1'b0;
        rel_vld = 1'b0;
        rel_cls = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_gnt_vld", gnt_vld, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_pool", pool_used, 0);
        chk("rst_rty", rty_used, 0);

        // class-0 quota is 4
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 4'(i + 1));
            #1 chk("s1_rdy", req_rdy, 1);
            tick();
            chk("s1_rsp_vld", rsp_vld, 1);
            chk("s1_rsp_retry", rsp_retry, 0);
            chk("s1_rsp_src", rsp_src, i + 1);
        end
        drive(0, 0, 0, 0, 0);
        chk("s1_pool4", pool_used, 4);
        // 5th request carries a stale credit: stalls like a new one
        drive(1, 0, 1, 0, 5);
        #1 chk("s1_5th_stall", req_rdy, 0);
        rel_vld = 1'b1;
        rel_cls = 2'd0;
        tick();
        rel_vld = 1'b0;
        chk("s1_no_rsp", rsp_vld, 0);
        chk("s1_pool3", pool_used, 3);
        #1 chk("s1_5th_rdy", req_rdy, 1);
        tick();
        chk("s1_5th_rsp", rsp_vld, 1);
        chk("s1_5th_retry", rsp_retry, 0);
        chk("s1_5th_src", rsp_src, 5);
        chk("s1_pool4b", pool_used, 4);
        drive(0, 0, 0, 0, 0);

        // underflow on empty class 2
        rel_vld = 1'b1;
        rel_cls = 2'd2;
        tick();
        rel_vld = 1'b0;
        chk("uf_err", err_underflow, 1);
        chk("uf_pool", pool_used, 4);

        // retry, grant, consume
        drive(1, 1, 0, 0, 3);
        #1 chk("s2_rdy", req_rdy, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("s2_rsp_vld", rsp_vld, 1);
        chk("s2_rsp_retry", rsp_retry, 1);
        chk("s2_rsp_src", rsp_src, 3);
        chk("s2_rty1", rty_used, 1);
        tick();
        chk("s2_no_gnt", gnt_vld, 0);
        rel_vld = 1'b1;
        rel_cls = 2'd0;
        tick();
        rel_vld = 1'b0;
        chk("s2_pool3", pool_used, 3);
        tick();
        chk("s2_gnt_vld", gnt_vld, 1);
        chk("s2_gnt_src", gnt_src, 3);
        chk("s2_gnt_cls", gnt_cls, 0);
        chk("s2_pool_resv", pool_used, 4);
        chk("s2_rty0", rty_used, 0);
        gnt_rdy = 1'b1;
        tick();
        gnt_rdy = 1'b0;
        chk("s2_gnt_drop", gnt_vld, 0);
        drive(1, 1, 1, 0, 3);
        #1 chk("s2_use_rdy", req_rdy, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("s2_use_rsp", rsp_vld, 1);
        chk("s2_use_retry", rsp_retry, 0);
        chk("s2_use_pool", pool_used, 4);

        // fill to 30: cls1 x8, cls2 x16, cls3 x2
        for (int i = 0; i < 26; i++) begin
            drive(1, 0, 0, (i < 8) ? 2'd1 : ((i < 24) ? 2'd2 : 2'd3),
                  4'(i));
            #1 chk("fill_rdy", req_rdy, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("fill_pool", pool_used, 30);

        // 16 retryable blocked: cls0 srcs 0-7, cls3 srcs 8-15
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, (i < 8) ? 2'd0 : 2'd3, 4'(i));
            #1 chk("q_rdy", req_rdy, 1);
            tick();
            chk("q_retry", rsp_retry, 1);
        end
        drive(0, 0, 0, 0, 0);
        chk("q_rty16", rty_used, 16);
        drive(1, 1, 0, 1, 0);
        #1 chk("q_17th_stall", req_rdy, 0);
        drive(0, 0, 0, 0, 0);

        // free one slot: cls3 beats cls0
        rel_vld = 1'b1;
        rel_cls = 2'd0;
        tick();
        rel_vld = 1'b0;
        chk("pr_pool29", pool_used, 29);
        chk("pr_no_gnt", gnt_vld, 0);
        tick();
        c0 = cyc;
        chk("pr_gnt_vld", gnt_vld, 1);
        chk("pr_gnt_cls", gnt_cls, 3);
        chk("pr_gnt_src", gnt_src, 8);
        chk("pr_pool30", pool_used, 30);
        chk("pr_rty15", rty_used, 15);

        // hold 5 cycles, with room freed in the first
        rel_vld = 1'b1;
        rel_cls = 2'd0;
        tick();
        rel_vld = 1'b0;
        repeat (4) tick();
        chk("hold_vld", gnt_vld, 1);
        chk("hold_src", gnt_src, 8);
        chk("hold_cls", gnt_cls, 3);
        chk("hold_pool", pool_used, 29);
        gnt_rdy = 1'b1;
        tick();
        chk("g2_src", gnt_src, 9);
        chk("g2_cls", gnt_cls, 3);
        chk("g2_pool", pool_used, 30);
        chk("g2_rty", rty_used, 14);

        // unconsumed credits: first reclaimed 64 cycles after grant
        n = 0;
        while (pool_used == 6'd30 && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", cyc - c0, 64);
        chk("to_pool", pool_used, 29);
        chk("to_gnt_idle", gnt_vld, 0);
        tick();
        gnt_rdy = 1'b0;
        chk("to_gnt_vld", gnt_vld, 1);
        chk("to_gnt_src", gnt_src, 10);
        chk("to_gnt_cls", gnt_cls, 3);
        chk("to_pool30", pool_used, 30);

        chk("uf_sticky", err_underflow, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", err_underflow, 0);
        chk("rst2_pool", pool_used, 0);
        chk("rst2_rty", rty_used, 0);
        chk("rst2_gnt", gnt_vld, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
